// File: rtl/mux2_4b_seq_if.sv
// Operand/select bus between the mux2_4b_seq sequencer and its controller.
//   D, Ld_A, Ld_B, Start, Abort : controller -> sequencer
//   A, B, S0, Busy, Done         : sequencer  -> controller / mux
interface mux2_4b_seq_if;
  logic [3:0] D;
  logic       Ld_A;
  logic       Ld_B;
  logic       Start;
  logic       Abort;
  logic [3:0] A;
  logic [3:0] B;
  logic       S0;
  logic       Busy;
  logic       Done;

  modport master (output D, Ld_A, Ld_B, Start, Abort,
                  input  A, B, S0, Busy, Done);
  modport slave  (input  D, Ld_A, Ld_B, Start, Abort,
                  output A, B, S0, Busy, Done);
endinterface

// File: rtl/mux2_4b_seq.sv
// Operand/select sequencer for a 4-bit 2:1 mux. Holds operands A/B and sweeps
// S0 low for DWELL cycles, then high for DWELL cycles, PASSES times per Start,
// then pulses Done for one cycle.
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : slave side of mux2_4b_seq_if (loads/start/abort in, A/B/S0/Busy/Done out)
// All outputs come straight from flops.
module mux2_4b_seq #(
  parameter int DWELL  = 10,  // 1..255
  parameter int PASSES = 1    // 1..15
) (
  input  logic          Clk,
  input  logic          Rst_n,
  mux2_4b_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} state_t;

  localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);
  localparam logic [3:0] PASSES_LAST = 4'(PASSES - 1);

  state_t     state;
  logic [7:0] dwell;
  logic [3:0] pass;
  logic [3:0] a_q, b_q;
  logic       s0_q, busy_q, done_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      dwell  <= '0;
      pass   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s0_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Loads land on the same edge as Start, so the sweep sees new data.
          if (bus.Ld_A) a_q <= bus.D;
          if (bus.Ld_B) b_q <= bus.D;
          if (bus.Start) begin
            state  <= RUN_A;
            dwell  <= '0;
            pass   <= '0;
            s0_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        RUN_A, RUN_B: begin
          // Abort wins over any dwell-expiry transition.
          if (bus.Abort) begin
            state  <= IDLE;
            dwell  <= '0;
            pass   <= '0;
            s0_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (dwell != DWELL_LAST) begin
            dwell <= dwell + 8'd1;
          end else if (state == RUN_A) begin
            state <= RUN_B;
            dwell <= '0;
            s0_q  <= 1'b1;
          end else if (pass == PASSES_LAST) begin
            state  <= DONE;
            dwell  <= '0;
            pass   <= '0;
            s0_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= RUN_A;
            dwell <= '0;
            pass  <= pass + 4'd1;
            s0_q  <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.S0   = s0_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_mux2_4b_seq.sv
// Directed bench for mux2_4b_seq: three instances cover DWELL/PASSES of
// (10,1), (3,2) and (4,1). Inputs change and outputs are sampled on negedge.
module tb_mux2_4b_seq;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic clk_run = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 if (clk_run) Clk = ~Clk;

  mux2_4b_seq_if i0 ();
  mux2_4b_seq_if i1 ();
  mux2_4b_seq_if i2 ();

  mux2_4b_seq #(.DWELL(10), .PASSES(1)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(i0));
  mux2_4b_seq #(.DWELL(3),  .PASSES(2)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(i1));
  mux2_4b_seq #(.DWELL(4),  .PASSES(1)) dut2 (.Clk(Clk), .Rst_n(Rst_n), .bus(i2));

  task automatic test_reset();
    @(negedge Clk);
    i0.D = 4'b1010; i0.Ld_A = 1'b1; i0.Ld_B = 1'b1;
    @(negedge Clk);
    i0.Ld_A = 1'b0; i0.Ld_B = 1'b0;
    checks++; if (i0.A !== 4'b1010) begin errors++; $display("FAIL rst_preload A got=%b exp=1010", i0.A); end
    clk_run = 1'b0;  // clock parked low
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (i0.A !== 4'b0000) begin errors++; $display("FAIL rst_async A got=%b exp=0000", i0.A); end
    checks++; if (i0.B !== 4'b0000) begin errors++; $display("FAIL rst_async B got=%b exp=0000", i0.B); end
    checks++; if (i0.S0 !== 1'b0) begin errors++; $display("FAIL rst_async S0 got=%b exp=0", i0.S0); end
    checks++; if (i0.Busy !== 1'b0) begin errors++; $display("FAIL rst_async Busy got=%b exp=0", i0.Busy); end
    checks++; if (i0.Done !== 1'b0) begin errors++; $display("FAIL rst_async Done got=%b exp=0", i0.Done); end
    #20;
    checks++; if (i0.A !== 4'b0000) begin errors++; $display("FAIL rst_hold A got=%b exp=0000", i0.A); end
    Rst_n = 1'b1;
    #1 clk_run = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    int ndone = 0;
    logic es0, ebusy, edone;
    logic [3:0] c;
    @(negedge Clk);
    i0.D = 4'b0000; i0.Ld_A = 1'b1;
    @(negedge Clk);
    i0.D = 4'b1111; i0.Ld_A = 1'b0; i0.Ld_B = 1'b1;
    @(negedge Clk);
    i0.Ld_B = 1'b0; i0.Start = 1'b1;
    @(negedge Clk);
    i0.Start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      es0   = (k >= 11 && k <= 20);
      ebusy = (k <= 20);
      edone = (k == 21);
      c = i0.S0 ? i0.B : i0.A;
      if (i0.Done) ndone++;
      checks++; if (i0.S0 !== es0) begin errors++; $display("FAIL basic_s0 k=%0d got=%b exp=%b", k, i0.S0, es0); end
      checks++; if (i0.Busy !== ebusy) begin errors++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, i0.Busy, ebusy); end
      checks++; if (i0.Done !== edone) begin errors++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, i0.Done, edone); end
      if (ebusy) begin
        checks++; if (c !== (es0 ? 4'b1111 : 4'b0000)) begin errors++; $display("FAIL basic_c k=%0d got=%b", k, c); end
      end
      @(negedge Clk);
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL basic_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_multi();
    logic [11:0] pat = 12'b000111000111;  // k=1 is the MSB
    int nbusy = 0;
    logic es0;
    @(negedge Clk);
    i1.D = 4'b0101; i1.Ld_A = 1'b1;
    @(negedge Clk);
    i1.D = 4'b1010; i1.Ld_A = 1'b0; i1.Ld_B = 1'b1;
    @(negedge Clk);
    i1.Ld_B = 1'b0; i1.Start = 1'b1;
    @(negedge Clk);
    i1.Start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      es0 = (k <= 12) ? pat[12-k] : 1'b0;
      if (i1.Busy) nbusy++;
      checks++; if (i1.S0 !== es0) begin errors++; $display("FAIL multi_s0 k=%0d got=%b exp=%b", k, i1.S0, es0); end
      checks++; if (i1.Done !== (k == 13)) begin errors++; $display("FAIL multi_done k=%0d got=%b", k, i1.Done); end
      @(negedge Clk);
    end
    checks++; if (nbusy != 12) begin errors++; $display("FAIL multi_nbusy got=%0d exp=12", nbusy); end
  endtask

  task automatic test_ignored();
    @(negedge Clk);
    i0.D = 4'b0011; i0.Ld_A = 1'b1;
    @(negedge Clk);
    i0.Ld_A = 1'b0; i0.Start = 1'b1;
    @(negedge Clk);
    i0.Start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      checks++; if (i0.A !== 4'b0011) begin errors++; $display("FAIL ign_a k=%0d got=%b exp=0011", k, i0.A); end
      checks++; if (i0.S0 !== (k >= 11 && k <= 20)) begin errors++; $display("FAIL ign_s0 k=%0d got=%b", k, i0.S0); end
      checks++; if (i0.Done !== (k == 21)) begin errors++; $display("FAIL ign_done k=%0d got=%b", k, i0.Done); end
      if (k == 12) begin i0.D = 4'b1111; i0.Ld_A = 1'b1; i0.Start = 1'b1; end
      if (k == 13) begin i0.Ld_A = 1'b0; i0.Start = 1'b0; end
      @(negedge Clk);
    end
  endtask

  task automatic test_abort();
    @(negedge Clk);
    i2.Start = 1'b1;
    @(negedge Clk);
    i2.Start = 1'b0;
    // Abort in the second RUN_B cycle.
    for (int k = 1; k <= 12; k++) begin
      checks++; if (i2.S0 !== (k == 5 || k == 6)) begin errors++; $display("FAIL abort_s0 k=%0d got=%b", k, i2.S0); end
      checks++; if (i2.Busy !== (k <= 6)) begin errors++; $display("FAIL abort_busy k=%0d got=%b", k, i2.Busy); end
      checks++; if (i2.Done !== 1'b0) begin errors++; $display("FAIL abort_done k=%0d got=%b exp=0", k, i2.Done); end
      i2.Abort = (k == 6 || k == 10);  // second one lands in IDLE, ignored
      @(negedge Clk);
    end
    i2.Abort = 1'b0;
    // Abort on the last RUN_A cycle beats the move to RUN_B.
    i2.Start = 1'b1;
    @(negedge Clk);
    i2.Start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (i2.S0 !== 1'b0) begin errors++; $display("FAIL abort_prio_s0 k=%0d got=%b exp=0", k, i2.S0); end
      checks++; if (i2.Busy !== (k <= 4)) begin errors++; $display("FAIL abort_prio_busy k=%0d got=%b", k, i2.Busy); end
      i2.Abort = (k == 4);
      @(negedge Clk);
    end
    i2.Abort = 1'b0;
    // Full sweep afterwards.
    i2.Start = 1'b1;
    @(negedge Clk);
    i2.Start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++; if (i2.S0 !== (k >= 5 && k <= 8)) begin errors++; $display("FAIL abort_rerun_s0 k=%0d got=%b", k, i2.S0); end
      checks++; if (i2.Done !== (k == 9)) begin errors++; $display("FAIL abort_rerun_done k=%0d got=%b", k, i2.Done); end
      @(negedge Clk);
    end
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (i1.Done !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    checks++; if (i1.Done !== 1'b1) begin errors++; $display("FAIL %s_timeout got=%b exp=1", tag, i1.Done); end
  endtask

  task automatic test_load_start();
    @(negedge Clk);
    i1.D = 4'b0110; i1.Ld_A = 1'b1; i1.Start = 1'b1;
    @(negedge Clk);
    i1.Ld_A = 1'b0; i1.Start = 1'b0;
    checks++; if (i1.A !== 4'b0110) begin errors++; $display("FAIL ldst_a got=%b exp=0110", i1.A); end
    checks++; if (i1.Busy !== 1'b1) begin errors++; $display("FAIL ldst_busy got=%b exp=1", i1.Busy); end
    wait_done1("ldst");
    @(negedge Clk);
    i1.D = 4'b1001; i1.Ld_A = 1'b1; i1.Ld_B = 1'b1; i1.Start = 1'b1;
    @(negedge Clk);
    i1.Ld_A = 1'b0; i1.Ld_B = 1'b0; i1.Start = 1'b0;
    checks++; if (i1.A !== 4'b1001) begin errors++; $display("FAIL ldst2_a got=%b exp=1001", i1.A); end
    checks++; if (i1.B !== 4'b1001) begin errors++; $display("FAIL ldst2_b got=%b exp=1001", i1.B); end
    checks++; if (i1.S0 !== 1'b0) begin errors++; $display("FAIL ldst2_s0 got=%b exp=0", i1.S0); end
    wait_done1("ldst2");
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    @(negedge Clk);
    i1.Start = 1'b1;
    @(negedge Clk);
    i1.Start = 1'b0;
    wait_done1("b2b");
    // Start held through the Done cycle and the following IDLE cycle.
    i1.Start = 1'b1;
    @(negedge Clk);
    checks++; if (i1.Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", i1.Busy); end
    @(negedge Clk);
    i1.Start = 1'b0;
    checks++; if (i1.Busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", i1.Busy); end
    wait_done1("b2b2");
    @(negedge Clk);
  endtask

  initial begin
    i0.D = '0; i0.Ld_A = 0; i0.Ld_B = 0; i0.Start = 0; i0.Abort = 0;
    i1.D = '0; i1.Ld_A = 0; i1.Ld_B = 0; i1.Start = 0; i1.Abort = 0;
    i2.D = '0; i2.Ld_A = 0; i2.Ld_B = 0; i2.Start = 0; i2.Abort = 0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    test_reset();
    test_basic();
    test_multi();
    test_ignored();
    test_abort();
    test_load_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux2_4b_seq.md
# mux2_4b_seq

Upstream operand/select sequencer for the 4-bit 2:1 multiplexer stage (Mux2_4b). It holds the two 4-bit operand words A and B in registers and drives the select S0 through a timed A-then-B sweep. It repeats the sweep a programmable number of passes and signals completion. This replaces hand-written select stimulus with a clocked source that the mux consumes directly.

## Interface

Parameters:
- DWELL, 10, cycles S0 is held at each value per pass; legal range 1..255.
- PASSES, 1, number of A→B sweeps per Start; legal range 1..15.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- D  in  4  operand load data.
- Ld_A  in  1  load D into A register; honoured only in IDLE.
- Ld_B  in  1  load D into B register; honoured only in IDLE.
- Start  in  1  begin sweep; honoured only in IDLE.
- Abort  in  1  terminate sweep; honoured only in RUN_A/RUN_B.
- A  out  4  operand A to mux (registered).
- B  out  4  operand B to mux (registered).
- S0  out  1  mux select: 0 selects A, 1 selects B (registered).
- Busy  out  1  high in RUN_A/RUN_B.
- Done  out  1  one-cycle pulse at normal sweep completion.

## Operation

- Reset (Rst_n=0, any time, including mid-sweep): A=0000, B=0000, S0=0, Busy=0, Done=0, state IDLE, dwell counter=0, pass counter=0. The reset takes effect immediately, without waiting for Clk.
- States: IDLE, RUN_A, RUN_B, DONE.
- IDLE:
  - Ld_A=1 → A<=D.
  - Ld_B=1 → B<=D.
  - Ld_A and Ld_B both high → both registers load D.
  - Start=1 → RUN_A, dwell counter=0, pass counter=0.
  - Load and Start in the same cycle → the load is applied and the sweep uses the new value.
- RUN_A: S0=0, Busy=1.
  - The dwell counter increments each cycle.
  - At count DWELL-1 → RUN_B, dwell counter cleared.
- RUN_B: S0=1, Busy=1.
  - At count DWELL-1: if pass counter = PASSES-1 → DONE; else pass counter+1 and → RUN_A.
- DONE: S0=0, Busy=0, Done=1 for exactly one cycle, then → IDLE.
- Abort in RUN_A or RUN_B → IDLE at the next edge: S0=0, Busy=0, no Done pulse, counters cleared.
- Abort has priority over a dwell-expiry transition in the same cycle.
- Abort in IDLE or DONE is ignored.
- Ld_A, Ld_B and Start are ignored outside IDLE. A and B stay stable throughout a sweep.
- Counter widths: dwell counter 8 bits, pass counter 4 bits. No wrap-around is reachable within the legal parameter ranges.

## Timing

- Start sampled high at edge t:
  - Busy=1 and S0=0 from t+1 through t+DWELL.
  - S0=1 from t+DWELL+1 through t+2·DWELL.
- One pass lasts 2·DWELL cycles.
- Done is high during cycle t+2·DWELL·PASSES+1; Busy is 0 in that cycle.
- IDLE is re-entered at the following edge. A new Start is accepted at the earliest one cycle after Done.
- Load latency: A/B outputs reflect D one cycle after the Ld edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Abort sampled at edge t → Busy=0 and S0=0 from t+1.

## Test plan

- Reset: drive Rst_n=0 mid-cycle with A=1010 loaded → A=B=0000, S0=0, Busy=0, Done=0 immediately; hold Clk stopped and confirm.
- Basic sweep (DWELL=10, PASSES=1): load A=0000, B=1111, then pulse Start.
  - S0=0 for 10 cycles, then S0=1 for 10 cycles.
  - Done pulses once at cycle 21 after Start. Mux C tracks 0000 then 1111.
- Multi-pass (DWELL=3, PASSES=2): load A=0101, B=1010, Start.
  - S0 sequence is 000111000111.
  - Done at cycle 13; Busy high for exactly 12 cycles.
- Ignored inputs: during RUN_B, assert Ld_A with D=1111 and Start → A unchanged, sweep timing unchanged.
- Abort: with DWELL=4, assert Abort on the 2nd RUN_B cycle → S0=0 and Busy=0 next cycle, Done never asserts. A new Start then runs a full sweep.
- Same-cycle load+Start in IDLE with D=0110 and Ld_A → A=0110 on the first RUN_A cycle. With Ld_A and Ld_B together, D=1001 → A=B=1001.
